bam_mul_arbiter: RTL

Shares one combinational broken-array multiplier core (e.g. an 8x8 unsigned CSA/CSkA BAM instance) between NREQ requesters. Each requester uses a valid/ready handshake. A round-robin arbiter feeds a 2-stage registered pipeline: an operand register drives the core, and a result register returns the product tagged with the requester index. It sits between accelerator lanes and the single approximate multiplier instance, so designs can trade area for throughput.

---
 rtl/bam_mul_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bam_mul_arbiter.sv
// Round-robin share of one combinational BAM multiplier core between NREQ valid/ready requesters.
// Operand register -> core -> result register: accept at edge t, response handshake from edge t+2; stalls ripple back from rsp_ready.
module bam_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic [CNTW-1:0]         op_count,
  output logic                    busy
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic                 s1_v_q, s1_v_d;
  logic [IDW-1:0]       s1_id_q, s1_id_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 s2_v_q, s2_v_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]      op_count_q, op_count_d;

  logic                 s1_ld, s2_ld;
  logic [2*NREQ-1:0]    req_rot;
  logic                 gnt_found, gnt_vld;
  logic [IDW:0]         gnt_sum;
  logic [IDW-1:0]       gnt_idx;

  assign s2_ld = !s2_v_q | rsp_ready;
  assign s1_ld = !s1_v_q | s2_ld;

  // Rotate so bit 0 is the rr_ptr requester; the lowest set bit then wins.
  always_comb begin
    req_rot   = {req_valid, req_valid} >> rr_ptr_q;
    gnt_found = 1'b0;
    gnt_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      end
    end
    gnt_idx = (gnt_sum >= NREQ_W) ? IDW'(gnt_sum - NREQ_W) : gnt_sum[IDW-1:0];
    gnt_vld = !rst & s1_ld & gnt_found;
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_id_d    = s1_id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rr_ptr_d   = rr_ptr_q;
    s2_v_d     = s2_v_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q;

    if (s1_ld) begin
      if (gnt_vld) begin
        s1_v_d   = 1'b1;
        s1_id_d  = gnt_idx;
        mul_a_d  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        mul_b_d  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        // Idle operands are zeroed so the core stops toggling.
        s1_v_d  = 1'b0;
        mul_a_d = '0;
        mul_b_d = '0;
      end
    end

    if (s2_ld) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        rsp_data_d = mul_p;
        rsp_id_d   = s1_id_q;
      end
    end

    if (s2_v_q && rsp_ready && (op_count_q != '1)) op_count_d = op_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_id_q    <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rr_ptr_q   <= '0;
      s2_v_q     <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_id_q    <= s1_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rr_ptr_q   <= rr_ptr_d;
      s2_v_q     <= s2_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = s2_v_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
  assign busy      = s1_v_q | s2_v_q;

endmodule
